axis_beam_combiner: RTL
=======================

AXIS_BEAM_COMBINER -- requirements
Module: axis_beam_combiner

Interface
REQ-001 Parameter CHANNELS, default 4: number of complex input streams, range 2..16.
REQ-002 Parameter SAMPLE_WIDTH, default 16: signed two's-complement bits per real or imag sample.
REQ-003 Parameter SAMPLES, default 8: samples per beat; DATA_WIDTH = SAMPLES*SAMPLE_WIDTH.
REQ-004 Parameter SHIFT, default 2: arithmetic right shift applied to each sum, range 0..clog2(CHANNELS).
REQ-005 Parameter SATURATE, default 1: 1 = clamp the result to SAMPLE_WIDTH; 0 = wrap, keeping the LSBs.
REQ-006 clock  in  1  sole clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 chan_mask  in  CHANNELS  1 = channel joins the sum; sampled on every beat.
REQ-009 s_axis_real_tdata / s_axis_imag_tdata  in  CHANNELS*DATA_WIDTH  packed inputs; channel c occupies slice c.
REQ-010 s_axis_real_tvalid / s_axis_imag_tvalid  in  CHANNELS  per-channel valid.
REQ-011 s_axis_real_tready / s_axis_imag_tready  out  CHANNELS  per-channel ready.
REQ-012 s_axis_real_tlast / s_axis_imag_tlast  in  CHANNELS  per-channel end of frame.
REQ-013 m_axis_real_tdata / m_axis_imag_tdata  out  DATA_WIDTH  summed samples.
REQ-014 m_axis_real_tkeep / m_axis_imag_tkeep  out  DATA_WIDTH/8  always all-ones when valid.
REQ-015 m_axis_tvalid, m_axis_tlast  out  1 each; one valid shared by real and imag.
REQ-016 m_axis_tready  in  1  downstream ready.
REQ-017 err_tlast_mismatch  out  1  sticky flag.
REQ-018 frame_count  out  32  count of output frames.

Function
REQ-019 Join condition: the input join fires when, for every enabled channel, both real and imag tvalid are high, and stage 1 can accept.
REQ-020 On a fire, all CHANNELS real and imag tready outputs are high in that cycle; otherwise all are low, so disabled channels are drained in lockstep.
REQ-021 tready is combinational from valids, chan_mask and pipeline state; tvalid never depends on tready.
REQ-022 Stage 1 registers, per sample, the sum of enabled channels (disabled channels contribute 0), at full width SAMPLE_WIDTH+clog2(CHANNELS).
REQ-023 Stage 2 applies the arithmetic SHIFT, then saturates or wraps per SATURATE, and registers the output.
REQ-024 Saturation bounds are +2^(SAMPLE_WIDTH-1)-1 and -2^(SAMPLE_WIDTH-1); clamping is applied independently per sample.
REQ-025 Latency is 2 cycles from fire to m_axis_tvalid when the pipeline is unstalled; throughput is 1 beat per cycle.
REQ-026 Stall rule: a stage advances when its successor is empty or is being consumed (m_axis_tvalid & m_axis_tready); no beat is dropped or duplicated.
REQ-027 While m_axis_tvalid is high and m_axis_tready is low, output data, tlast and tkeep are held stable.
REQ-028 m_axis_tlast equals the real tlast of the lowest-indexed enabled channel at fire.
REQ-029 err_tlast_mismatch sets if any enabled real or imag tlast differs from that value at fire; it clears only on reset.
REQ-030 frame_count increments on each output handshake with tlast high, wrapping at 2^32-1 to 0.
REQ-031 If chan_mask is all-zero, no join fires and all tready outputs are low.
REQ-032 A chan_mask change takes effect on the next fire; beats already in flight are unaffected.

Reset
REQ-033 On reset, the pipeline valids, m_axis_tvalid, m_axis_tlast, tdata, tkeep, err_tlast_mismatch, frame_count and all tready outputs go to 0 at the next edge.
REQ-034 Reset asserted mid-stream discards in-flight beats; the first fire after reset is deasserted is accepted normally.

Structure
REQ-035 A shared package axis_beam_pkg holds the sum-width function, saturation bounds and the per-channel slice-index helper.
REQ-036 Sub-module beam_sum_lane (one sample lane: sum, shift, saturate) is instantiated SAMPLES times for each of real and imag.

Verification
REQ-037 CHANNELS=4, SHIFT=0, all inputs real=0x1000, imag=0xF000, mask=0xF -> real=0x4000, imag=0xC000 (-16384) after 2 cycles.
REQ-038 Real inputs all 0x7FFF, SHIFT=0, SATURATE=1 -> output 0x7FFF; same stimulus with SATURATE=0 -> 0xFFFC.
REQ-039 Mask=0x5, channel 1 tvalid held low, channels 0 and 2 at 0x0100 -> output 0x0200, and all four tready outputs pulse together.
REQ-040 m_axis_tready low for 5 cycles during a 10-beat burst -> 10 beats out, in order, with data stable while stalled.
REQ-041 Channel 0 tlast=1, channel 2 tlast=0 at the same fire -> err_tlast_mismatch=1 and sticky; frame_count increments by 1.
REQ-042 Reset pulsed with 2 beats in flight -> m_axis_tvalid=0 the next cycle; the next fire appears 2 cycles later.

Source files
------------

// File: rtl/axis_beam_pkg.sv
// Shared helpers for the beam combiner: accumulator width, clamp bounds
// and the bit offset of one sample inside the packed multi-channel buses.
package axis_beam_pkg;

  // Width that holds the sum of `channels` signed samples without overflow.
  function automatic int sum_width(input int sample_width, input int channels);
    return sample_width + $clog2(channels);
  endfunction

  // Largest positive value representable in sample_width signed bits.
  function automatic longint sat_max(input int sample_width);
    return (longint'(1) <<< (sample_width - 1)) - 1;
  endfunction

  // Most negative value representable in sample_width signed bits.
  function automatic longint sat_min(input int sample_width);
    return -(longint'(1) <<< (sample_width - 1));
  endfunction

  // LSB position of sample `samp` of channel `chan` in a packed input bus.
  function automatic int slice_lo(input int chan, input int samp,
                                  input int samples, input int sample_width);
    return (chan * samples + samp) * sample_width;
  endfunction

endpackage

// File: rtl/beam_sum_lane.sv
// One sample lane: masked sum across channels (stage 1), then arithmetic
// shift and clamp/wrap back to the sample width (stage 2).
module beam_sum_lane
  import axis_beam_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SHIFT        = 2,
  parameter int SATURATE     = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             load_sum,
  input  logic                             load_out,
  input  logic [CHANNELS-1:0]              chan_mask,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] samples_in,
  output logic [SAMPLE_WIDTH-1:0]          sample_out
);

  localparam int SUM_W = sum_width(SAMPLE_WIDTH, CHANNELS);
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'(sat_max(SAMPLE_WIDTH));
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(sat_min(SAMPLE_WIDTH));

  logic signed [SUM_W-1:0]        sum_next;
  logic signed [SUM_W-1:0]        sum_q;
  logic signed [SUM_W-1:0]        shifted;
  logic        [SAMPLE_WIDTH-1:0] out_next;

  // Full-width sum of the enabled channels; disabled channels add nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_mask[c]) begin
        sum_next = sum_next + SUM_W'($signed(samples_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
      end
    end
  end

  // Scale the registered sum, then clamp or keep the low bits.
  always_comb begin
    shifted  = sum_q >>> SHIFT;
    out_next = shifted[SAMPLE_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (shifted > MAX_V)      out_next = MAX_V[SAMPLE_WIDTH-1:0];
      else if (shifted < MIN_V) out_next = MIN_V[SAMPLE_WIDTH-1:0];
    end
  end

  // Pipeline registers for this lane, loaded by the shared control.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: datapath registers are cleared too because the output data must read zero after reset.
      sum_q      <= '0;
      sample_out <= '0;
    end else begin
      if (load_sum) sum_q      <= sum_next;
      if (load_out) sample_out <= out_next;
    end
  end

endmodule

// File: rtl/axis_beam_combiner.sv
// Joins CHANNELS complex AXI-Stream inputs in lockstep and emits their
// masked, scaled sum through a two-stage stallable pipeline.
module axis_beam_combiner
  import axis_beam_pkg::*;
#(
  parameter int  CHANNELS     = 4,
  parameter int  SAMPLE_WIDTH = 16,
  parameter int  SAMPLES      = 8,
  parameter int  SHIFT        = 2,
  parameter int  SATURATE     = 1,
  localparam int DATA_WIDTH   = SAMPLES * SAMPLE_WIDTH,
  localparam int KEEP_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            chan_mask,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_real_tdata,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_imag_tdata,
  input  logic [CHANNELS-1:0]            s_axis_real_tvalid,
  input  logic [CHANNELS-1:0]            s_axis_imag_tvalid,
  output logic [CHANNELS-1:0]            s_axis_real_tready,
  output logic [CHANNELS-1:0]            s_axis_imag_tready,
  input  logic [CHANNELS-1:0]            s_axis_real_tlast,
  input  logic [CHANNELS-1:0]            s_axis_imag_tlast,
  output logic [DATA_WIDTH-1:0]          m_axis_real_tdata,
  output logic [DATA_WIDTH-1:0]          m_axis_imag_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_real_tkeep,
  output logic [KEEP_WIDTH-1:0]          m_axis_imag_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           err_tlast_mismatch,
  output logic [31:0]                    frame_count
);

  logic s1_valid, s1_last;
  logic join_ok, ref_last, last_err;
  logic adv_out, s1_ready, fire;
  logic [SAMPLES-1:0][CHANNELS*SAMPLE_WIDTH-1:0] real_lane_in, imag_lane_in;

  // Join check: every enabled channel valid on both rails; tlast reference
  // is the real tlast of the lowest enabled channel.
  always_comb begin
    join_ok  = |chan_mask;
    ref_last = 1'b0;
    last_err = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (chan_mask[c]) ref_last = s_axis_real_tlast[c];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_mask[c]) begin
        if (!(s_axis_real_tvalid[c] && s_axis_imag_tvalid[c])) join_ok = 1'b0;
        if (s_axis_real_tlast[c] != ref_last || s_axis_imag_tlast[c] != ref_last) last_err = 1'b1;
      end
    end
  end

  assign adv_out  = s1_valid && (!m_axis_tvalid || m_axis_tready);
  assign s1_ready = !s1_valid || adv_out;
  assign fire     = join_ok && s1_ready && !reset;

  assign s_axis_real_tready = {CHANNELS{fire}};
  assign s_axis_imag_tready = {CHANNELS{fire}};
  assign m_axis_real_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};
  assign m_axis_imag_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};

  // Pipeline occupancy, frame tag, sticky tlast error and frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid           <= 1'b0;
      s1_last            <= 1'b0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      err_tlast_mismatch <= 1'b0;
      frame_count        <= '0;
    end else begin
      if (fire) begin
        s1_valid <= 1'b1;
        s1_last  <= ref_last;
        if (last_err) err_tlast_mismatch <= 1'b1;
      end else if (adv_out) begin
        s1_valid <= 1'b0;
      end
      if (adv_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s1_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_count <= frame_count + 32'd1;
    end
  end

  for (genvar s = 0; s < SAMPLES; s++) begin : g_lane
    for (genvar c = 0; c < CHANNELS; c++) begin : g_gather
      assign real_lane_in[s][c*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        s_axis_real_tdata[slice_lo(c, s, SAMPLES, SAMPLE_WIDTH) +: SAMPLE_WIDTH];
      assign imag_lane_in[s][c*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        s_axis_imag_tdata[slice_lo(c, s, SAMPLES, SAMPLE_WIDTH) +: SAMPLE_WIDTH];
    end

    beam_sum_lane #(
      .CHANNELS(CHANNELS), .SAMPLE_WIDTH(SAMPLE_WIDTH), .SHIFT(SHIFT), .SATURATE(SATURATE)
    ) u_real (
      .clock(clock), .reset(reset), .load_sum(fire), .load_out(adv_out),
      .chan_mask(chan_mask), .samples_in(real_lane_in[s]),
      .sample_out(m_axis_real_tdata[s*SAMPLE_WIDTH +: SAMPLE_WIDTH])
    );

    beam_sum_lane #(
      .CHANNELS(CHANNELS), .SAMPLE_WIDTH(SAMPLE_WIDTH), .SHIFT(SHIFT), .SATURATE(SATURATE)
    ) u_imag (
      .clock(clock), .reset(reset), .load_sum(fire), .load_out(adv_out),
      .chan_mask(chan_mask), .samples_in(imag_lane_in[s]),
      .sample_out(m_axis_imag_tdata[s*SAMPLE_WIDTH +: SAMPLE_WIDTH])
    );
  end

endmodule
